song_player: RTL and testbench

- Chart sequencer at the far end of the game-flow FSM interface.
- Consumes the FSM's state code and song_confirm pulse, and latches the chosen song.
- During PLAY, steps through that song's note chart in an external synchronous ROM at a fixed step rate and drives the current lane pattern to the LED-matrix renderer.
- Returns finish to the FSM when the chart ends.

---
 rtl/song_player.sv | 246 ++++++++++++++++++++++++
 tb/tb_song_player.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/song_player.sv
// -----------------------------------------------------------------------------
// song_player
//
// Chart sequencer that sits behind the game-flow FSM. It latches the song the
// player confirms in the menu and, while the game is in PLAY, walks that
// song's note chart in an external chart ROM. Each step is shown to the
// LED-matrix renderer for TICK_DIV clocks. When the chart ends, finish is
// raised back to the game FSM.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   state        game FSM state code: 0 START, 1 MENU, 2 PLAY, 3 FINISH
//   song_confirm one-cycle song number (1..3) from the game FSM; 0 = none
//   rom_addr     chart ROM address {song_id, step}
//   rom_data     chart ROM word: [3] end marker, [2:0] lanes {yellow,blue,red}
//                The word must be valid one cycle after rom_addr changes.
//   lanes        lane pattern of the step currently displayed
//   lane_strobe  one-cycle pulse whenever lanes is loaded from the chart
//   step_idx     index of the step currently displayed
//   song_id      latched song number, 1..3
//   busy         high while a chart is running
//   finish       chart-complete level, held until the game leaves PLAY
//
// Parameters
//   TICK_DIV     clocks per chart step (minimum 4)
//   STEP_W       step index width; a chart holds up to 2**STEP_W steps
// -----------------------------------------------------------------------------
module song_player #(
    parameter int TICK_DIV = 2500000,
    parameter int STEP_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        state,
    input  logic [1:0]        song_confirm,
    output logic [STEP_W+1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [2:0]        lanes,
    output logic              lane_strobe,
    output logic [STEP_W-1:0] step_idx,
    output logic [1:0]        song_id,
    output logic              busy,
    output logic              finish
);

    // The tick counter must be able to hold TICK_DIV itself (see SHOW).
    localparam int TICK_W = $clog2(TICK_DIV + 1);

    localparam logic [1:0] GAME_MENU = 2'd1;
    localparam logic [1:0] GAME_PLAY = 2'd2;

    // tick holds the 1-based display clock of the current step. The FETCH
    // cycle that loads the next pattern is the last display clock of the
    // previous step, so a normal step leaves SHOW at TICK_DIV-1 while the
    // final step stays in SHOW through TICK_DIV. Every step, including the
    // last one, is therefore visible for exactly TICK_DIV clocks.
    localparam logic [TICK_W-1:0] TICK_ADDR = TICK_W'(TICK_DIV - 2);
    localparam logic [TICK_W-1:0] TICK_NEXT = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    localparam logic [STEP_W-1:0] STEP_MAX  = {STEP_W{1'b1}};
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2,
        DONE  = 2'd3
    } seq_t;

    seq_t              seq_reg,      seq_next;
    logic [STEP_W+1:0] rom_addr_reg, rom_addr_next;
    logic [2:0]        lanes_reg,    lanes_next;
    logic              strobe_reg,   strobe_next;
    logic [STEP_W-1:0] step_idx_reg, step_idx_next;
    logic [1:0]        song_reg,     song_next;
    logic              busy_reg,     busy_next;
    logic              finish_reg,   finish_next;
    logic [TICK_W-1:0] tick_reg,     tick_next;
    logic [STEP_W-1:0] step_reg,     step_next;
    logic              end_reg,      end_next;

    logic              play;
    logic [STEP_W-1:0] step_inc;

    assign play     = (state == GAME_PLAY);
    assign step_inc = step_reg + STEP_ONE;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_reg      <= IDLE;
            rom_addr_reg <= '0;
            lanes_reg    <= '0;
            strobe_reg   <= 1'b0;
            step_idx_reg <= '0;
            song_reg     <= 2'd1;
            busy_reg     <= 1'b0;
            finish_reg   <= 1'b0;
            tick_reg     <= '0;
            step_reg     <= '0;
            end_reg      <= 1'b0;
        end else begin
            seq_reg      <= seq_next;
            rom_addr_reg <= rom_addr_next;
            lanes_reg    <= lanes_next;
            strobe_reg   <= strobe_next;
            step_idx_reg <= step_idx_next;
            song_reg     <= song_next;
            busy_reg     <= busy_next;
            finish_reg   <= finish_next;
            tick_reg     <= tick_next;
            step_reg     <= step_next;
            end_reg      <= end_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        seq_next = seq_reg;
        case (seq_reg)
            IDLE: begin
                if (play) begin
                    seq_next = FETCH;
                end
            end
            FETCH: begin
                seq_next = play ? SHOW : IDLE;
            end
            SHOW: begin
                if (!play) begin
                    seq_next = IDLE;
                end else if (end_reg && (tick_reg == TICK_LAST)) begin
                    seq_next = DONE;
                end else if (!end_reg && (tick_reg == TICK_NEXT)) begin
                    seq_next = FETCH;
                end
            end
            DONE: begin
                if (!play) begin
                    seq_next = IDLE;
                end
            end
            default: begin
                seq_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        rom_addr_next = rom_addr_reg;
        lanes_next    = lanes_reg;
        strobe_next   = 1'b0;
        step_idx_next = step_idx_reg;
        busy_next     = busy_reg;
        finish_next   = finish_reg;
        tick_next     = tick_reg;
        step_next     = step_reg;
        end_next      = end_reg;

        // Song selection only counts in the menu, which also guarantees that
        // the song cannot change underneath a running chart.
        song_next = song_reg;
        if ((state == GAME_MENU) && (song_confirm != 2'd0)) begin
            song_next = song_confirm;
        end

        case (seq_reg)
            IDLE: begin
                if (play) begin
                    rom_addr_next = {song_reg, {STEP_W{1'b0}}};
                    step_next     = '0;
                    busy_next     = 1'b1;
                    tick_next     = '0;
                    end_next      = 1'b0;
                end
            end
            FETCH: begin
                if (play) begin
                    lanes_next    = rom_data[2:0];
                    strobe_next   = 1'b1;
                    step_idx_next = step_reg;
                    tick_next     = TICK_ONE;
                    // The last addressable step ends the chart even without
                    // a marker, so the step counter never wraps into the
                    // next song's region.
                    end_next      = rom_data[3] | (step_reg == STEP_MAX);
                end else begin
                    lanes_next    = '0;
                    busy_next     = 1'b0;
                    step_idx_next = '0;
                    tick_next     = '0;
                end
            end
            SHOW: begin
                if (!play) begin
                    lanes_next    = '0;
                    busy_next     = 1'b0;
                    step_idx_next = '0;
                    tick_next     = '0;
                end else begin
                    tick_next = tick_reg + TICK_ONE;
                    if (end_reg) begin
                        if (tick_reg == TICK_LAST) begin
                            lanes_next  = '0;
                            busy_next   = 1'b0;
                            finish_next = 1'b1;
                        end
                    end else if (tick_reg == TICK_ADDR) begin
                        // Address moves two clocks before the load so the
                        // ROM word is settled when FETCH samples it.
                        step_next     = step_inc;
                        rom_addr_next = {song_reg, step_inc};
                    end
                end
            end
            DONE: begin
                if (!play) begin
                    finish_next = 1'b0;
                end
            end
            default: begin
                lanes_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign rom_addr    = rom_addr_reg;
    assign lanes       = lanes_reg;
    assign lane_strobe = strobe_reg;
    assign step_idx    = step_idx_reg;
    assign song_id     = song_reg;
    assign busy        = busy_reg;
    assign finish      = finish_reg;

endmodule

// File: tb/tb_song_player.sv
// -----------------------------------------------------------------------------
// tb_song_player
//
// Directed sequence with randomized chart contents and random song_confirm
// noise, checked cycle by cycle against a timeline computed from the chart:
// step k of an n-step chart is loaded TICK_DIV*k+1 clocks after PLAY is first
// seen, and finish rises TICK_DIV*n+1 clocks after it.
// -----------------------------------------------------------------------------
module tb_song_player;

    localparam int TD = 4;
    localparam int SW = 3;
    localparam int NSTEP = 1 << SW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    state = 2'd0;
    logic [1:0]    song_confirm = 2'd0;
    logic [SW+1:0] rom_addr;
    logic [3:0]    rom_data;
    logic [2:0]    lanes;
    logic          lane_strobe;
    logic [SW-1:0] step_idx;
    logic [1:0]    song_id;
    logic          busy;
    logic          finish;

    logic [3:0]    rom [0:4*NSTEP-1];

    int checks   = 0;
    int failures = 0;

    song_player #(
        .TICK_DIV (TD),
        .STEP_W   (SW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .state        (state),
        .song_confirm (song_confirm),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .lanes        (lanes),
        .lane_strobe  (lane_strobe),
        .step_idx     (step_idx),
        .song_id      (song_id),
        .busy         (busy),
        .finish       (finish)
    );

    always #5 clk = ~clk;

    // Chart ROM: word is ready well inside one cycle of the address.
    assign rom_data = rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of steps that will be displayed for song s.
    function automatic int chart_len(input int s);
        for (int k = 0; k < NSTEP; k++) begin
            if (rom[s*NSTEP + k][3]) return k + 1;
        end
        return NSTEP;
    endfunction

    task automatic fill_song(input int s, input int endpos);
        for (int k = 0; k < NSTEP; k++) begin
            rom[s*NSTEP + k] = {(k == endpos), 3'($urandom_range(0, 7))};
        end
    endtask

    // Expected outputs c clocks after the edge that first saw PLAY (c=0).
    task automatic check_cycle(input int s, input int c, input int n);
        int    k;
        string t;
        t = $sformatf("s%0d c%0d", s, c);
        chk({t, " song_id"}, song_id, s);
        if (c == 0) begin
            chk({t, " busy"}, busy, 1);
            chk({t, " lanes"}, lanes, 0);
            chk({t, " strobe"}, lane_strobe, 0);
            chk({t, " finish"}, finish, 0);
            chk({t, " rom_addr"}, rom_addr, s*NSTEP);
        end else if (c <= n*TD) begin
            k = (c - 1) / TD;
            chk({t, " lanes"}, lanes, rom[s*NSTEP + k][2:0]);
            chk({t, " strobe"}, lane_strobe, ((c - 1) % TD) == 0);
            chk({t, " step_idx"}, step_idx, k);
            chk({t, " busy"}, busy, 1);
            chk({t, " finish"}, finish, 0);
            chk({t, " rom_song"}, rom_addr[SW+1:SW], s);
            if (((c - 1) % TD) == 0) chk({t, " rom_addr"}, rom_addr, s*NSTEP + k);
        end else begin
            chk({t, " lanes"}, lanes, 0);
            chk({t, " busy"}, busy, 0);
            chk({t, " finish"}, finish, 1);
            chk({t, " strobe"}, lane_strobe, 0);
            chk({t, " step_idx"}, step_idx, n - 1);
        end
    endtask

    task automatic confirm(input int s);
        state        = 2'd1;
        song_confirm = 2'(s);
        @(posedge clk); #1;
        song_confirm = 2'd0;
        $display("confirm song=%0d song_id=%0d", s, song_id);
        chk("confirm song_id", song_id, s);
    endtask

    // Runs song s in PLAY. abort_c >= 0 drops back to MENU after clock abort_c.
    task automatic play(input int s, input int abort_c);
        int n;
        n     = chart_len(s);
        state = 2'd2;
        for (int c = 0; c <= n*TD + 1; c++) begin
            song_confirm = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            check_cycle(s, c, n);
            if (c == abort_c) begin
                state        = 2'd1;
                song_confirm = 2'd0;
                @(posedge clk); #1;
                $display("abort song=%0d at c=%0d lanes=%0d busy=%0b", s, c, lanes, busy);
                chk("abort lanes", lanes, 0);
                chk("abort busy", busy, 0);
                chk("abort step_idx", step_idx, 0);
                chk("abort strobe", lane_strobe, 0);
                chk("abort finish", finish, 0);
                repeat (TD + 2) begin
                    @(posedge clk); #1;
                    chk("after abort finish", finish, 0);
                    chk("after abort busy", busy, 0);
                end
                return;
            end
        end
        song_confirm = 2'd0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("hold finish", finish, 1);
            chk("hold busy", busy, 0);
            chk("hold lanes", lanes, 0);
        end
        state = 2'd3;
        @(posedge clk); #1;
        chk("leave finish", finish, 0);
        chk("leave busy", busy, 0);
        state = 2'd0;
        @(posedge clk); #1;
        chk("idle finish", finish, 0);
        $display("play song=%0d steps=%0d done", s, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 4*NSTEP; i++) rom[i] = 4'($urandom_range(0, 15));

        // Reset values while rst is held.
        #12;
        chk("rst rom_addr", rom_addr, 0);
        chk("rst lanes", lanes, 0);
        chk("rst strobe", lane_strobe, 0);
        chk("rst step_idx", step_idx, 0);
        chk("rst song_id", song_id, 1);
        chk("rst busy", busy, 0);
        chk("rst finish", finish, 0);
        $display("reset song_id=%0d busy=%0b", song_id, busy);
        rst = 1'b0;
        @(posedge clk); #1;

        // Song 2: three steps, end marker on the last one.
        rom[2*NSTEP + 0] = 4'b0001;
        rom[2*NSTEP + 1] = 4'b0010;
        rom[2*NSTEP + 2] = 4'b1100;
        confirm(2);
        play(2, -1);

        // Song 1 without any end marker: runs all steps, never wraps.
        fill_song(1, NSTEP);
        confirm(1);
        play(1, -1);

        // Abort during step 1, then song 3 from its base address.
        fill_song(3, 4);
        confirm(3);
        play(3, TD + 2);
        confirm(3);
        play(3, -1);

        // Confirms outside MENU, or zero in MENU, are ignored.
        state = 2'd0; song_confirm = 2'd1;
        @(posedge clk); #1;
        chk("ignore start song_id", song_id, 3);
        state = 2'd3; song_confirm = 2'd1;
        @(posedge clk); #1;
        chk("ignore finish song_id", song_id, 3);
        state = 2'd1; song_confirm = 2'd0;
        @(posedge clk); #1;
        chk("ignore zero song_id", song_id, 3);
        state = 2'd0;

        // Random charts and songs.
        for (int it = 0; it < 5; it++) begin
            int s;
            s = $urandom_range(1, 3);
            fill_song(s, $urandom_range(0, NSTEP));
            confirm(s);
            play(s, -1);
        end

        // Asynchronous reset in the middle of a running chart.
        fill_song(3, NSTEP);
        confirm(3);
        n     = chart_len(3);
        state = 2'd2;
        for (int c = 0; c <= 2*TD; c++) begin
            @(posedge clk); #1;
            check_cycle(3, c, n);
        end
        #2 rst = 1'b1;
        #1;
        $display("mid-run reset lanes=%0d busy=%0b song_id=%0d", lanes, busy, song_id);
        chk("midrst rom_addr", rom_addr, 0);
        chk("midrst lanes", lanes, 0);
        chk("midrst strobe", lane_strobe, 0);
        chk("midrst step_idx", step_idx, 0);
        chk("midrst song_id", song_id, 1);
        chk("midrst busy", busy, 0);
        chk("midrst finish", finish, 0);
        rst = 1'b0;
        // PLAY still asserted: restarts from step 0 with the reset song.
        play(1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
